// File: rtl/instruction_encoder.sv
// RV64I instruction word encoder: packs decoded fields plus a signed immediate into a
// 32-bit word and streams it out with sequential byte addresses over valid/ready.
module instruction_encoder #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [63:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_fits12;
  logic              w_fits13;
  logic              w_fits21;
  logic              w_fits32;
  logic [31:0]       w_instr;
  logic              w_fmtBad;
  logic              w_alignBad;
  logic              w_rangeBad;
  logic [1:0]        w_code;
  logic              w_accept;
  logic              w_good;
  logic              w_bad;
  logic              w_drain;

  // An immediate fits n signed bits when bits [63:n-1] are all copies of the sign.
  assign w_fits12 = (&imm[63:11]) | ~(|imm[63:11]);
  assign w_fits13 = (&imm[63:12]) | ~(|imm[63:12]);
  assign w_fits21 = (&imm[63:20]) | ~(|imm[63:20]);
  assign w_fits32 = (&imm[63:31]) | ~(|imm[63:31]);

  always_comb begin
    w_instr    = '0;
    w_fmtBad   = 1'b0;
    w_alignBad = 1'b0;
    w_rangeBad = 1'b0;
    case (fmt)
      3'd0: begin
        w_instr    = {imm[11:0], rs1, funct3, rd, opcode};
        w_rangeBad = !w_fits12;
      end
      3'd1: begin
        w_instr    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_rangeBad = !w_fits12;
      end
      3'd2: begin
        w_instr    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_rangeBad = !w_fits13;
        w_alignBad = imm[0];
      end
      3'd3: begin
        w_instr    = {imm[31:12], rd, opcode};
        w_rangeBad = !w_fits32;
        w_alignBad = |imm[11:0];
      end
      3'd4: begin
        w_instr    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_rangeBad = !w_fits21;
        w_alignBad = imm[0];
      end
      3'd5: begin
        w_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      default: begin
        w_fmtBad = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_code = 2'b00;
    if (w_fmtBad)        w_code = 2'b11;
    else if (w_alignBad) w_code = 2'b10;
    else if (w_rangeBad) w_code = 2'b01;
  end

  assign in_ready = (r_state == RUN) && !r_err && (!r_out_valid || out_ready) && !stop;
  assign w_accept = in_valid && in_ready;
  assign w_good   = w_accept && (w_code == 2'b00);
  assign w_bad    = w_accept && (w_code != 2'b00);
  assign w_drain  = r_out_valid && out_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN: begin
        if (w_bad)                     w_next = ERROR;
        else if (stop && !r_out_valid) w_next = IDLE;
      end
      ERROR:   if (clear) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // A word pending when an error hits still drains; only the failing bundle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= '0;
      r_addr      <= '0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      if (w_good) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_instr;
        r_out_addr  <= r_addr;
        r_addr      <= r_addr + ADDR_W'(4);
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end

      if (r_state == IDLE && base_load)
        r_addr <= base_addr & ~ADDR_W'(3);

      if (r_state == IDLE && start) r_count <= '0;
      else if (w_drain)             r_count <= r_count + CNT_W'(1);

      if (w_bad) begin
        r_err      <= 1'b1;
        r_err_code <= w_code;
      end else if (r_state == ERROR && clear) begin
        r_err      <= 1'b0;
        r_err_code <= 2'b00;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign count     = r_count;
  assign busy      = (r_state != IDLE);
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed, table-driven bench for instruction_encoder: good encodings, backpressure,
// stop draining, error codes/priority, address wrap and mid-transfer reset.
module tb_instruction_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    logic [31:0] expInstr;
    logic [1:0]  expCode;
  } vec_t;

  localparam int NGOOD = 11;
  localparam int NERR  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        clear;
  logic        base_load;
  logic [63:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_addr;
  logic [15:0] count;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  vec_t goodVec[NGOOD];
  vec_t errVec[NERR];

  instruction_encoder #(.ADDR_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .base_load(base_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .count(count), .busy(busy), .err(err), .err_code(err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid = 1'b1;
    fmt      = v.fmt;
    opcode   = v.opcode;
    rd       = v.rd;
    rs1      = v.rs1;
    rs2      = v.rs2;
    funct3   = v.funct3;
    funct7   = v.funct7;
    imm      = v.imm;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inverse of the encoding, used to confirm the immediate survives the round trip.
  function automatic logic [63:0] decodeImm(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'd0:    return {{52{w[31]}}, w[31:20]};
      3'd1:    return {{52{w[31]}}, w[31:25], w[11:7]};
      3'd2:    return {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd3:    return {{32{w[31]}}, w[31:12], 12'b0};
      3'd4:    return {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 64'd0;
    endcase
  endfunction

  initial begin
    logic [15:0] expCount;

    goodVec[0]  = '{3'd0, 7'h13, 5'd5,  5'd6,  5'd0,  3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF30293, 2'd0};
    goodVec[1]  = '{3'd1, 7'h23, 5'd31, 5'd2,  5'd7,  3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFE712E23, 2'd0};
    goodVec[2]  = '{3'd2, 7'h63, 5'd0,  5'd10, 5'd11, 3'd1, 7'h00, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFEB51CE3, 2'd0};
    goodVec[3]  = '{3'd3, 7'h37, 5'd10, 5'd3,  5'd0,  3'd0, 7'h00, 64'h0000_0000_1234_5000, 32'h12345537, 2'd0};
    goodVec[4]  = '{3'd4, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 64'h0000_0000_0000_0800, 32'h001000EF, 2'd0};
    goodVec[5]  = '{3'd5, 7'h33, 5'd3,  5'd4,  5'd5,  3'd0, 7'h20, 64'h0000_0000_0000_DEAD, 32'h405201B3, 2'd0};
    goodVec[6]  = '{3'd0, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 64'h0000_0000_0000_07FF, 32'h7FF00093, 2'd0};
    goodVec[7]  = '{3'd0, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_F800, 32'h80000093, 2'd0};
    goodVec[8]  = '{3'd3, 7'h37, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_F000, 32'hFFFFF2B7, 2'd0};
    goodVec[9]  = '{3'd4, 7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 64'h0000_0000_000F_FFFE, 32'h7FFFF06F, 2'd0};
    goodVec[10] = '{3'd2, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_F000, 32'h80000063, 2'd0};

    errVec[0] = '{3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'h0000_0000_0000_1000, 32'h0, 2'b01};
    errVec[1] = '{3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0000_0003, 32'h0, 2'b10};
    errVec[2] = '{3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0000_0000, 32'h0, 2'b11};
    errVec[3] = '{3'd3, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0000_0801, 32'h0, 2'b10};
    errVec[4] = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0000_1388, 32'h0, 2'b01};
    errVec[5] = '{3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'h0000_0000_0000_1001, 32'h0, 2'b10};
    errVec[6] = '{3'd7, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0000_0001, 32'h0, 2'b11};
    errVec[7] = '{3'd3, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0001_0000_0000, 32'h0, 2'b01};
    errVec[8] = '{3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 64'h0000_0000_0000_0800, 32'h0, 2'b01};
    errVec[9] = '{3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0010_0000, 32'h0, 2'b01};

    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; base_load = 1'b0;
    base_addr = '0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (3) tick();

    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_instr", out_instr, 0);
    checkOutput("rst_out_addr",  out_addr,  0);
    checkOutput("rst_count",     count,     0);
    checkOutput("rst_err",       err,       0);
    checkOutput("rst_err_code",  err_code,  0);
    checkOutput("rst_busy",      busy,      0);
    checkOutput("rst_in_ready",  in_ready,  0);
    reset = 1'b0;
    tick();

    base_addr = 64'h1000; base_load = 1'b1; start = 1'b1;
    tick();
    base_load = 1'b0; start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_count", count, 0);

    // Back-to-back stream at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < NGOOD; i++) begin
      applyStimulus(goodVec[i]);
      #1;
      checkOutput($sformatf("stream%0d_in_ready", i), in_ready, 1);
      tick();
      checkOutput($sformatf("stream%0d_valid", i), out_valid, 1);
      checkOutput($sformatf("stream%0d_instr", i), out_instr, goodVec[i].expInstr);
      checkOutput($sformatf("stream%0d_addr", i), out_addr, 64'h1000 + 64'(4 * i));
      checkOutput($sformatf("stream%0d_count", i), count, 64'(i));
      if (goodVec[i].fmt != 3'd5)
        checkOutput($sformatf("stream%0d_decode", i), decodeImm(out_instr, goodVec[i].fmt), goodVec[i].imm);
    end
    in_valid = 1'b0;
    tick();
    checkOutput("stream_end_valid", out_valid, 0);
    checkOutput("stream_end_count", count, NGOOD);

    // Backpressure: hold out_ready low for three cycles with a bundle waiting.
    applyStimulus(goodVec[0]);
    tick();
    out_ready = 1'b0;
    applyStimulus(goodVec[1]);
    #1;
    checkOutput("bp_in_ready_low", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("bp%0d_valid", k), out_valid, 1);
      checkOutput($sformatf("bp%0d_instr", k), out_instr, goodVec[0].expInstr);
      checkOutput($sformatf("bp%0d_addr", k), out_addr, 64'h102C);
      checkOutput($sformatf("bp%0d_in_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", in_ready, 1);
    tick();
    checkOutput("bp_w1_instr", out_instr, goodVec[1].expInstr);
    checkOutput("bp_w1_addr", out_addr, 64'h1030);
    applyStimulus(goodVec[2]);
    tick();
    checkOutput("bp_w2_instr", out_instr, goodVec[2].expInstr);
    checkOutput("bp_w2_addr", out_addr, 64'h1034);
    in_valid = 1'b0;
    tick();
    checkOutput("bp_end_valid", out_valid, 0);
    checkOutput("bp_end_count", count, NGOOD + 3);

    // Stop while a word is pending: stay busy until it drains, then go idle.
    out_ready = 1'b0;
    applyStimulus(goodVec[3]);
    tick();
    in_valid = 1'b0;
    stop = 1'b1;
    #1;
    checkOutput("stop_in_ready", in_ready, 0);
    tick();
    checkOutput("stop_hold_busy", busy, 1);
    checkOutput("stop_hold_valid", out_valid, 1);
    checkOutput("stop_hold_addr", out_addr, 64'h1038);
    out_ready = 1'b1;
    tick();
    checkOutput("stop_drain_valid", out_valid, 0);
    checkOutput("stop_drain_busy", busy, 1);
    tick();
    checkOutput("stop_idle_busy", busy, 0);
    checkOutput("stop_count", count, NGOOD + 4);
    stop = 1'b0;

    // Misaligned base is rounded down; start zeroes the count.
    base_addr = 64'h2003; base_load = 1'b1; start = 1'b1;
    tick();
    base_load = 1'b0; start = 1'b0;
    checkOutput("restart_count", count, 0);
    applyStimulus(goodVec[0]);
    tick();
    checkOutput("base_align_addr", out_addr, 64'h2000);
    checkOutput("base_align_valid", out_valid, 1);

    // Each bad bundle is consumed, latches its code and emits nothing.
    expCount = 16'd1;
    for (int k = 0; k < NERR; k++) begin
      applyStimulus(errVec[k]);
      tick();
      in_valid = 1'b0;
      checkOutput($sformatf("err%0d_err", k), err, 1);
      checkOutput($sformatf("err%0d_code", k), err_code, errVec[k].expCode);
      checkOutput($sformatf("err%0d_valid", k), out_valid, 0);
      checkOutput($sformatf("err%0d_in_ready", k), in_ready, 0);
      checkOutput($sformatf("err%0d_busy", k), busy, 1);
      checkOutput($sformatf("err%0d_count", k), count, expCount);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput($sformatf("clr%0d_err", k), err, 0);
      checkOutput($sformatf("clr%0d_code", k), err_code, 0);
      checkOutput($sformatf("clr%0d_busy", k), busy, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      expCount = 16'd0;
    end
    applyStimulus(goodVec[0]);
    tick();
    checkOutput("post_err_addr", out_addr, 64'h2004);
    checkOutput("post_err_instr", out_instr, goodVec[0].expInstr);
    in_valid = 1'b0;
    tick();
    checkOutput("post_err_count", count, 1);

    // Address wraps past the top of the address space.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checkOutput("wrap_pre_idle", busy, 0);
    base_addr = 64'hFFFF_FFFF_FFFF_FFFC; base_load = 1'b1; start = 1'b1;
    tick();
    base_load = 1'b0; start = 1'b0;
    applyStimulus(goodVec[6]);
    tick();
    checkOutput("wrap_addr_top", out_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(goodVec[7]);
    tick();
    checkOutput("wrap_addr_zero", out_addr, 64'h0);
    checkOutput("wrap_instr", out_instr, goodVec[7].expInstr);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    checkOutput("pre_reset_valid", out_valid, 1);
    checkOutput("pre_reset_count", count, 1);

    // Reset with a word pending discards it.
    reset = 1'b1;
    tick();
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_count", count, 0);
    checkOutput("midrst_err", err, 0);
    checkOutput("midrst_addr", out_addr, 0);
    checkOutput("midrst_instr", out_instr, 0);
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
